score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter FRAMES_PER_POINT, 30, number of vsync falling edges per score increment (range 1..255).
REQ-002 clk  input  1  pixel clock (the 25 MHz VGA clock); all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  run switch; level-sensitive; 1 requests a game.
REQ-005 game_over  input  1  collision flag from the background/game stage; level-sensitive.
REQ-006 vsync  input  1  active-low VGA vertical sync from the game stage.
REQ-007 hex0..hex5  output  7 each  active-low seven-segment patterns, bit0 = segment a ... bit6 = segment g.
REQ-008 state_leds  output  3  one-hot state indication: bit0 IDLE, bit1 RUNNING, bit2 OVER.
REQ-009 new_record  output  1  high while in OVER if the last game set a new high score.

Function
REQ-010 Frame tick SHALL be vsync registered once (vsync_q) and asserted for one cycle when vsync_q=1 and vsync=0; tick is one cycle after the falling edge.
REQ-011 FSM states SHALL be IDLE, RUNNING and OVER.
REQ-012 IDLE -> RUNNING when start=1 and game_over=0; on this transition score, frame_cnt and new_record SHALL clear to 0.
REQ-013 IDLE SHALL remain IDLE while game_over=1, regardless of start.
REQ-014 RUNNING: each tick SHALL increment frame_cnt; on a tick with frame_cnt=FRAMES_PER_POINT-1, frame_cnt SHALL become 0 and score SHALL increment by 1.
REQ-015 Score SHALL be 3-digit BCD (000..999), per-digit carry, saturating at 999 (further increments ignored).
REQ-016 RUNNING -> OVER when game_over=1; game_over SHALL take priority over a same-cycle tick (no increment).
REQ-017 RUNNING -> IDLE when start=0 and game_over=0; score SHALL be held, high score SHALL NOT update.
REQ-018 On RUNNING -> OVER, if score > hi_score then hi_score SHALL load score and new_record SHALL set, both in the transition cycle; equal score SHALL NOT set new_record.
REQ-019 OVER -> IDLE when start=0; OVER SHALL hold score and hi_score.
REQ-020 hex2/hex1/hex0 SHALL show score hundreds/tens/units; hex5/hex4/hex3 SHALL show hi_score hundreds/tens/units.
REQ-021 Hex outputs SHALL be registered: one cycle of latency from a score/hi_score register change.
REQ-022 Digit codes 10..15 SHALL decode to all-segments-off (7'b1111111).

Reset
REQ-023 Asserting rst SHALL immediately force: state IDLE, score 0, hi_score 0, frame_cnt 0, vsync_q 1, new_record 0.
REQ-024 During reset, hex0..hex5 SHALL be 7'b1000000 ("0") and state_leds SHALL be 3'b001.
REQ-025 Reset mid-game SHALL discard the running score and the high score without entering OVER.

Structure
REQ-026 State encodings, the "0" and blank segment constants, and the FRAMES_PER_POINT default SHALL live in a shared include file used by the game modules.
REQ-027 One sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low out, combinational), SHALL be instantiated six times.

Verification
REQ-028 Reset, then start=1, 90 vsync falling edges (FRAMES_PER_POINT=30) -> hex2..hex0 = "003", state_leds=3'b010.
REQ-029 Preload score to 099 by 2970 edges, one further point -> hex2..hex0 = "100"; run to 999 plus 30 edges -> stays "999".
REQ-030 Score 005, game_over=1 on the same cycle as the 30th tick -> state OVER, score 005, hi_score 005, new_record=1.
REQ-031 Second game ends at 003 -> hi_score stays 005, new_record=0; third game ends at 005 -> new_record=0.
REQ-032 start=0 mid-game at score 004 -> IDLE, hex shows 004, hi_score unchanged; start=1 with game_over=1 -> remains IDLE.
REQ-033 rst asserted asynchronously (between clock edges) in RUNNING at score 012 -> outputs reset values before the next clock edge; after release, start=1 -> count resumes from 000.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper and its display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package score_keeper_pkg;

  // Game FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  // Three-digit BCD score, hundreds in d2.
  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd3_t;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One-hot state indication for the LEDs.
  localparam logic [2:0] LEDS_IDLE    = 3'b001;
  localparam logic [2:0] LEDS_RUNNING = 3'b010;
  localparam logic [2:0] LEDS_OVER    = 3'b100;

  localparam int unsigned FRAMES_PER_POINT_DEF = 30;

  // Increment a BCD score with per-digit carry, holding at 999.
  function automatic bcd3_t bcd_inc_sat(input bcd3_t v);
    bcd3_t r;
    r = v;
    if (v.d2 == 4'd9 && v.d1 == 4'd9 && v.d0 == 4'd9) begin
      r = v;
    end else if (v.d0 != 4'd9) begin
      r.d0 = v.d0 + 4'd1;
    end else begin
      r.d0 = 4'd0;
      if (v.d1 != 4'd9) begin
        r.d1 = v.d1 + 4'd1;
      end else begin
        r.d1 = 4'd0;
        r.d2 = v.d2 + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-stage control inputs and seven-segment/LED display outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-sensitive.
`timescale 1ns/1ps
interface score_keeper_if;
  logic       start;
  logic       game_over;
  logic       vsync;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;
  logic [6:0] hex4;
  logic [6:0] hex5;
  logic [2:0] state_leds;
  logic       new_record;

  // Driver side: the game stage / board switches.
  modport master (
    output start, game_over, vsync,
    input  hex0, hex1, hex2, hex3, hex4, hex5, state_leds, new_record
  );

  // Score keeper side.
  modport slave (
    input  start, game_over, vsync,
    output hex0, hex1, hex2, hex3, hex4, hex5, state_leds, new_record
  );
endinterface

// File: rtl/score_keeper_seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; codes 10..15 blank.
// Latency: combinational.
// Backpressure: none.
`timescale 1ns/1ps
module seg7_decoder
  import score_keeper_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Segment lookup, gfedcba active-low.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_ZERO;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Counts frames while a game runs, keeps score and high score, drives hex/LEDs.
// Latency: score moves on the cycle after a vsync fall; hex follows one cycle later.
// Backpressure: none; inputs are level-sensitive and sampled every cycle.
`timescale 1ns/1ps
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned FRAMES_PER_POINT = FRAMES_PER_POINT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  score_keeper_if.slave bus
);

  localparam logic [7:0] LP_LAST_FRAME = 8'(FRAMES_PER_POINT - 1);

  logic       r_vsync_q;
  logic       w_tick;
  state_t     r_state;
  bcd3_t      r_score;
  bcd3_t      r_hi;
  logic [7:0] r_frame_cnt;
  logic       r_new_record;
  logic [2:0] r_leds;
  logic [3:0] w_digit [6];
  logic [6:0] w_seg   [6];
  logic [6:0] r_hex   [6];

  // Delay vsync one cycle so its falling edge can be detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vsync_q <= 1'b1;
    else     r_vsync_q <= bus.vsync;
  end

  assign w_tick = r_vsync_q & ~bus.vsync;

  // Game FSM with score, high score, frame counter and registered indicators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_score      <= '0;
      r_hi         <= '0;
      r_frame_cnt  <= '0;
      r_new_record <= 1'b0;
      r_leds       <= LEDS_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.game_over) begin
            r_state      <= ST_RUNNING;
            r_score      <= '0;
            r_frame_cnt  <= '0;
            r_new_record <= 1'b0;
            r_leds       <= LEDS_RUNNING;
          end
        end
        ST_RUNNING: begin
          // A collision wins over a coincident frame tick.
          if (bus.game_over) begin
            r_state <= ST_OVER;
            r_leds  <= LEDS_OVER;
            if (12'(r_score) > 12'(r_hi)) begin
              r_hi         <= r_score;
              r_new_record <= 1'b1;
            end
          end else if (!bus.start) begin
            r_state <= ST_IDLE;
            r_leds  <= LEDS_IDLE;
          end else if (w_tick) begin
            if (r_frame_cnt == LP_LAST_FRAME) begin
              r_frame_cnt <= '0;
              r_score     <= bcd_inc_sat(r_score);
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        ST_OVER: begin
          // The record flag only describes the game just finished.
          if (!bus.start) begin
            r_state      <= ST_IDLE;
            r_leds       <= LEDS_IDLE;
            r_new_record <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_leds  <= LEDS_IDLE;
        end
      endcase
    end
  end

  assign w_digit[0] = r_score.d0;
  assign w_digit[1] = r_score.d1;
  assign w_digit[2] = r_score.d2;
  assign w_digit[3] = r_hi.d0;
  assign w_digit[4] = r_hi.d1;
  assign w_digit[5] = r_hi.d2;

  for (genvar g = 0; g < 6; g++) begin : g_dec
    seg7_decoder u_dec (
      .i_bcd (w_digit[g]),
      .o_seg (w_seg[g])
    );
  end

  // Register the decoded patterns so the display is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) r_hex[i] <= SEG_ZERO;
    end else begin
      for (int i = 0; i < 6; i++) r_hex[i] <= w_seg[i];
    end
  end

  assign bus.hex0       = r_hex[0];
  assign bus.hex1       = r_hex[1];
  assign bus.hex2       = r_hex[2];
  assign bus.hex3       = r_hex[3];
  assign bus.hex4       = r_hex[4];
  assign bus.hex5       = r_hex[5];
  assign bus.state_leds = r_leds;
  assign bus.new_record = r_new_record;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: vector table plus hand-written corner sequences.
// Latency: checks sampled on falling clock edges after settle cycles.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_score_keeper;

  typedef struct {
    logic        st;
    logic        go;
    int          edges;
    logic [11:0] score;
    logic [11:0] hi;
    logic [2:0]  leds;
    logic        nr;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs [18];

  score_keeper_if u_if ();

  score_keeper #(.FRAMES_PER_POINT(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h7f;
    endcase
    return s;
  endfunction

  function automatic logic [41:0] exp_hex(input logic [11:0] s, input logic [11:0] h);
    return {seg_of(h[11:8]), seg_of(h[7:4]), seg_of(h[3:0]),
            seg_of(s[11:8]), seg_of(s[7:4]), seg_of(s[3:0])};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [11:0] s, input logic [11:0] h,
                           input logic [2:0] leds, input logic nr);
    check({name, "_hex"},
          64'({u_if.hex5, u_if.hex4, u_if.hex3, u_if.hex2, u_if.hex1, u_if.hex0}),
          64'(exp_hex(s, h)));
    check({name, "_leds"}, 64'(u_if.state_leds), 64'(leds));
    check({name, "_nr"}, 64'(u_if.new_record), 64'(nr));
  endtask

  task automatic pulse_vsync(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      u_if.vsync = 1'b0;
      @(negedge clk);
      u_if.vsync = 1'b1;
    end
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      u_if.start     = vecs[i].st;
      u_if.game_over = vecs[i].go;
      repeat (2) @(negedge clk);
      pulse_vsync(vecs[i].edges);
      repeat (3) @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].score, vecs[i].hi, vecs[i].leds, vecs[i].nr);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all("in_reset", 12'h000, 12'h000, 3'b001, 1'b0);
    u_if.start     = 1'b0;
    u_if.game_over = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //           st    go    edges  score    hi       leds    nr
    vecs[0]  = '{1'b1, 1'b0, 90,    12'h003, 12'h000, 3'b010, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2880,  12'h099, 12'h000, 3'b010, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 30,    12'h100, 12'h000, 3'b010, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 26970, 12'h999, 12'h000, 3'b010, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 30,    12'h999, 12'h000, 3'b010, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 150,   12'h005, 12'h000, 3'b010, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 0,     12'h005, 12'h005, 3'b001, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 90,    12'h003, 12'h005, 3'b010, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 0,     12'h003, 12'h005, 3'b100, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 0,     12'h003, 12'h005, 3'b001, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 150,   12'h005, 12'h005, 3'b010, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 0,     12'h005, 12'h005, 3'b100, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 0,     12'h005, 12'h005, 3'b001, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 120,   12'h004, 12'h005, 3'b010, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 0,     12'h004, 12'h005, 3'b001, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 0,     12'h004, 12'h005, 3'b001, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 360,   12'h012, 12'h005, 3'b010, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 30,    12'h001, 12'h000, 3'b010, 1'b0};

    rst            = 1'b1;
    u_if.start     = 1'b0;
    u_if.game_over = 1'b0;
    u_if.vsync     = 1'b1;
    repeat (2) @(negedge clk);
    check_all("reset", 12'h000, 12'h000, 3'b001, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all("idle_after_reset", 12'h000, 12'h000, 3'b001, 1'b0);

    // Counting, BCD carry and saturation.
    run_range(0, 4);

    // Fresh state for the high-score games.
    apply_reset();
    repeat (2) @(negedge clk);
    check_all("idle_after_reset2", 12'h000, 12'h000, 3'b001, 1'b0);
    run_range(5, 5);

    // Collision in the same cycle as the 30th tick: no increment, new record.
    pulse_vsync(29);
    @(negedge clk);
    u_if.vsync     = 1'b0;
    u_if.game_over = 1'b1;
    @(negedge clk);
    u_if.vsync = 1'b1;
    repeat (3) @(negedge clk);
    check_all("over_same_tick", 12'h005, 12'h005, 3'b100, 1'b1);

    run_range(6, 16);

    // Asynchronous reset between clock edges while running at 012.
    #5;
    rst = 1'b1;
    #1;
    check_all("async_reset", 12'h000, 12'h000, 3'b001, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all("resume_000", 12'h000, 12'h000, 3'b010, 1'b0);
    run_range(17, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
